// File: rtl/byte_perm_scrambler.sv
// byte_perm_scrambler: table-driven multi-round byte lane permute+offset scrambler; optional inverse mode under SCR_INVERSE_EN
module byte_perm_scrambler #(
    parameter int NUM_BYTES = 27,
    parameter int ROUNDS_W  = 8,
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   cfg_we_i,
    input  logic [IW-1:0]          cfg_idx_i,
    input  logic [IW-1:0]          cfg_src_i,
    input  logic [7:0]             cfg_off_i,
    input  logic                   start_i,
    input  logic                   mode_i,
    input  logic [ROUNDS_W-1:0]    rounds_i,
    input  logic [8*NUM_BYTES-1:0] din_i,
    output logic [8*NUM_BYTES-1:0] dout_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic [IW:0] NB = (IW+1)'(NUM_BYTES);
    state_e state_q, state_d;
    logic [ROUNDS_W-1:0] cnt_q, cnt_d;
    logic mode_q, mode_d, err_q, err_d;
    logic [8*NUM_BYTES-1:0] dout_q, dout_d, fwd, inv, rnd;
    logic [IW-1:0] src_q [NUM_BYTES];
    logic [7:0] off_q [NUM_BYTES];
    logic cfg_ok, reject, mode_eff;
    assign cfg_ok = cfg_we_i && state_q == IDLE && ({1'b0, cfg_idx_i} < NB) && ({1'b0, cfg_src_i} < NB);
    // routing/offset table, identity after reset, writable only while idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                src_q[i] <= IW'(i);
                off_q[i] <= '0;
            end
        end else if (cfg_ok) begin
            src_q[cfg_idx_i] <= cfg_src_i;
            off_q[cfg_idx_i] <= cfg_off_i;
        end
    end
    // forward round: each lane gathers its source lane and adds its offset
    always_comb begin
        fwd = dout_q;
        for (int i = 0; i < NUM_BYTES; i++)
            fwd[8*i +: 8] = dout_q[{src_q[i], 3'b000} +: 8] + off_q[i];
    end
`ifdef SCR_INVERSE_EN
    logic [NUM_BYTES-1:0] seen;
    // inverse round scatters back to the source lane; seen marks every lane referenced by the table
    always_comb begin
        inv = dout_q;
        seen = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            inv[{src_q[i], 3'b000} +: 8] = dout_q[8*i +: 8] - off_q[i];
            seen[src_q[i]] = 1'b1;
        end
    end
    assign reject = mode_i && !(&seen);
    assign mode_eff = mode_i;
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign inv = fwd;
    assign reject = 1'b0;
    assign mode_eff = 1'b0;
`endif
    assign rnd = mode_q ? inv : fwd;
    // job control: accept in IDLE, one round per enabled cycle in RUN, single-cycle DONE
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        mode_d = mode_q;
        dout_d = dout_q;
        err_d = 1'b0;
        unique case (state_q)
            IDLE: if (start_i) begin
                if (reject) err_d = 1'b1;
                else begin
                    dout_d = din_i;
                    cnt_d = rounds_i;
                    mode_d = mode_eff;
                    state_d = (rounds_i == '0) ? DONE : RUN;
                end
            end
            RUN: if (en_i) begin
                dout_d = rnd;
                cnt_d = cnt_q - ROUNDS_W'(1);
                if (cnt_q == ROUNDS_W'(1)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q <= '0;
            mode_q <= 1'b0;
            dout_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            mode_q <= mode_d;
            dout_q <= dout_d;
            err_q <= err_d;
        end
    end
    assign dout_o = dout_q;
    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
    assign err_o = err_q;
endmodule
